// File: rtl/transmitter.sv
// UART packet receiver feeding a BPSK modulator.
// RX assembles framed bytes into packets; a one-deep slot decouples the two.
module transmitter #(
   parameter int DATA_WIDTH         = 8,
   parameter int PACKET_SIZE        = 16,
   parameter int CLKS_PER_BIT       = 4,
   parameter int SAMPLES_PER_SYMBOL = 8,
   parameter int AMPLITUDE          = 2 ** (DATA_WIDTH - 2)
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic                         uart_stream,
   output logic signed [DATA_WIDTH-1:0] signal,
   output logic                         tx_active,
   output logic                         frame_err,
   output logic                         overrun
);

   localparam int NB  = PACKET_SIZE / 8;
   localparam int BCW = (NB > 1) ? $clog2(NB) : 1;
   localparam int CW  = $clog2(CLKS_PER_BIT);
   localparam int KW  = $clog2(SAMPLES_PER_SYMBOL);
   localparam int SW  = $clog2(PACKET_SIZE);

   localparam logic [CW-1:0]  HALF_M1 = CW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [CW-1:0]  BIT_M1  = CW'(CLKS_PER_BIT - 1);
   localparam logic [KW-1:0]  K_LAST  = KW'(SAMPLES_PER_SYMBOL - 1);
   localparam logic [KW-1:0]  K_HALF  = KW'(SAMPLES_PER_SYMBOL / 2);
   localparam logic [SW-1:0]  S_LAST  = SW'(PACKET_SIZE - 1);
   localparam logic [BCW-1:0] B_LAST  = BCW'(NB - 1);
   localparam logic signed [DATA_WIDTH-1:0] AMP =
      DATA_WIDTH'(AMPLITUDE);

   typedef enum logic [2:0] {
      R_IDLE,
      R_START,
      R_DATA,
      R_PARITY,
      R_STOP
   } rx_state_t;

   typedef enum logic {
      M_IDLE,
      M_SEND
   } mod_state_t;

   logic                   sync1_q, sync2_q, prev_q;
   rx_state_t              rstate_q, rstate_d;
   logic [CW-1:0]          cnt_q, cnt_d;
   logic [2:0]             bit_q, bit_d;
   logic [7:0]             byte_q, byte_d;
   logic                   par_err_q, par_err_d;
   logic [BCW-1:0]         bc_q, bc_d;
   logic [PACKET_SIZE-1:0] asm_q, asm_d;
   logic                   done_q, done_d;
   logic [PACKET_SIZE-1:0] hold_q, hold_d;
   logic                   hold_valid_q, hold_valid_d;

   mod_state_t             mstate_q, mstate_d;
   logic [PACKET_SIZE-1:0] shift_q, shift_d;
   logic [KW-1:0]          k_q, k_d;
   logic [SW-1:0]          sym_q, sym_d;
   logic signed [DATA_WIDTH-1:0] signal_q, signal_d;
   logic                   active_q, active_d;

   logic                   tick, ferr, ovr, load;
   logic signed [DATA_WIDTH-1:0] carrier;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sync1_q      <= 1'b1;
         sync2_q      <= 1'b1;
         prev_q       <= 1'b1;
         rstate_q     <= R_IDLE;
         cnt_q        <= '0;
         bit_q        <= '0;
         byte_q       <= '0;
         par_err_q    <= 1'b0;
         bc_q         <= '0;
         asm_q        <= '0;
         done_q       <= 1'b0;
         hold_q       <= '0;
         hold_valid_q <= 1'b0;
         mstate_q     <= M_IDLE;
         shift_q      <= '0;
         k_q          <= '0;
         sym_q        <= '0;
         signal_q     <= '0;
         active_q     <= 1'b0;
      end else begin
         sync1_q      <= uart_stream;
         sync2_q      <= sync1_q;
         prev_q       <= sync2_q;
         rstate_q     <= rstate_d;
         cnt_q        <= cnt_d;
         bit_q        <= bit_d;
         byte_q       <= byte_d;
         par_err_q    <= par_err_d;
         bc_q         <= bc_d;
         asm_q        <= asm_d;
         done_q       <= done_d;
         hold_q       <= hold_d;
         hold_valid_q <= hold_valid_d;
         mstate_q     <= mstate_d;
         shift_q      <= shift_d;
         k_q          <= k_d;
         sym_q        <= sym_d;
         signal_q     <= signal_d;
         active_q     <= active_d;
      end
   end

   assign tick = (cnt_q == BIT_M1);

   always_comb begin
      rstate_d  = rstate_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      byte_d    = byte_q;
      par_err_d = par_err_q;
      bc_d      = bc_q;
      asm_d     = asm_q;
      done_d    = 1'b0;
      ferr      = 1'b0;
      if (rstate_q == R_DATA || rstate_q == R_PARITY ||
          rstate_q == R_STOP) begin
         cnt_d = tick ? '0 : cnt_q + 1'b1;
      end
      unique case (rstate_q)
         R_IDLE: begin
            // Edge-triggered, so after a bad stop the line must rise first
            if (prev_q && !sync2_q) begin
               rstate_d = R_START;
               cnt_d    = '0;
            end
         end
         R_START: begin
            if (cnt_q == HALF_M1) begin
               cnt_d    = '0;
               bit_d    = '0;
               rstate_d = sync2_q ? R_IDLE : R_DATA;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
         end
         R_DATA: begin
            if (tick) begin
               byte_d = {sync2_q, byte_q[7:1]};
               bit_d  = bit_q + 3'd1;
               if (bit_q == 3'd7) rstate_d = R_PARITY;
            end
         end
         R_PARITY: begin
            if (tick) begin
               par_err_d = sync2_q ^ (^byte_q);
               rstate_d  = R_STOP;
            end
         end
         R_STOP: begin
            if (tick) begin
               rstate_d = R_IDLE;
               if (!sync2_q || par_err_q) begin
                  ferr = 1'b1;
               end else begin
                  for (int i = 0; i < NB; i++) begin
                     if (bc_q == BCW'(i)) asm_d[i*8 +: 8] = byte_q;
                  end
                  if (bc_q == B_LAST) begin
                     bc_d   = '0;
                     done_d = 1'b1;
                  end else begin
                     bc_d = bc_q + 1'b1;
                  end
               end
            end
         end
         default: rstate_d = R_IDLE;
      endcase
   end

   always_comb begin
      mstate_d = mstate_q;
      shift_d  = shift_q;
      k_d      = k_q;
      sym_d    = sym_q;
      load     = 1'b0;
      unique case (mstate_q)
         M_IDLE: begin
            if (hold_valid_q) begin
               load     = 1'b1;
               mstate_d = M_SEND;
               shift_d  = hold_q;
               k_d      = '0;
               sym_d    = '0;
            end
         end
         M_SEND: begin
            if (k_q == K_LAST) begin
               k_d = '0;
               if (sym_q == S_LAST) begin
                  sym_d = '0;
                  if (hold_valid_q) begin
                     load    = 1'b1;
                     shift_d = hold_q;
                  end else begin
                     mstate_d = M_IDLE;
                  end
               end else begin
                  sym_d   = sym_q + 1'b1;
                  shift_d = shift_q >> 1;
               end
            end else begin
               k_d = k_q + 1'b1;
            end
         end
      endcase

      // A load on the completion cycle frees the slot for the new packet
      hold_d       = hold_q;
      hold_valid_d = hold_valid_q;
      ovr          = 1'b0;
      if (load) hold_valid_d = 1'b0;
      if (done_q) begin
         if (hold_valid_q && !load) begin
            ovr = 1'b1;
         end else begin
            hold_d       = asm_q;
            hold_valid_d = 1'b1;
         end
      end

      carrier  = (k_d < K_HALF) ? AMP : -AMP;
      signal_d = '0;
      active_d = 1'b0;
      if (mstate_d == M_SEND) begin
         active_d = 1'b1;
         signal_d = shift_d[0] ? carrier : -carrier;
      end
   end

   assign signal    = signal_q;
   assign tx_active = active_q;
   assign frame_err = ferr & rst_n;
   assign overrun   = ovr & rst_n;

endmodule
